fetch_stage: RTL and testbench

//  Instruction-fetch stage and IF/ID pipeline register for the 5-stage core.

---
 rtl/fetch_stage.sv | 111 +++++++++++
 tb/tb_fetch_stage.sv | 131 +++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with PC register, synchronous imem read port and IF/ID register.
// Holds the fetched word locally while Decode is stalled so instr_D stays stable.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_F,
  input  logic        stall_D,
  input  logic        flush_D,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc4_D,
  output logic        valid_D,
  output logic        misalign_D
);

  logic        go;

  logic [31:0] pc_f_q,       pc_f_d;
  logic [31:0] pc_d_q,       pc_d_d;
  logic        valid_q,      valid_d;
  logic        misalign_q,   misalign_d;
  logic        hold_vld_q,   hold_vld_d;
  logic [31:0] hold_instr_q, hold_instr_d;

  assign go        = ~stall_F & ~stall_D;
  assign imem_en   = go & ~redirect_en & ~reset;
  assign imem_addr = {pc_f_q[31:2], 2'b00};

  // Redirect overrides any stall; otherwise advance only when both stages move.
  always_comb begin
    pc_f_d = pc_f_q;
    if (redirect_en) begin
      pc_f_d = redirect_pc;
    end else if (go) begin
      pc_f_d = pc_f_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f_q <= RESET_PC;
    end else begin
      pc_f_q <= pc_f_d;
    end
  end

  // Memory data is only valid one cycle after the read, so on the first stalled
  // edge it is captured into the hold buffer and served from there afterwards.
  always_comb begin
    pc_d_d       = pc_d_q;
    valid_d      = valid_q;
    misalign_d   = misalign_q;
    hold_vld_d   = hold_vld_q;
    hold_instr_d = hold_instr_q;
    if (flush_D | redirect_en) begin
      valid_d    = 1'b0;
      misalign_d = 1'b0;
      hold_vld_d = 1'b0;
    end else if (~stall_D) begin
      pc_d_d     = pc_f_q;
      valid_d    = imem_en;
      misalign_d = imem_en & (|pc_f_q[1:0]);
      hold_vld_d = 1'b0;
    end else if (valid_q & ~hold_vld_q) begin
      hold_instr_d = imem_rdata;
      hold_vld_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_d_q     <= '0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      hold_vld_q <= 1'b0;
    end else begin
      pc_d_q     <= pc_d_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
      hold_vld_q <= hold_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    hold_instr_q <= hold_instr_d;
  end

  always_comb begin
    if (~valid_q | misalign_q) begin
      instr_D = NOP;
    end else if (hold_vld_q) begin
      instr_D = hold_instr_q;
    end else begin
      instr_D = imem_rdata;
    end
  end

  assign pc_D       = pc_d_q;
  assign pc4_D      = pc_d_q + 32'd4;
  assign valid_D    = valid_q;
  assign misalign_D = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector table plus hand-written corner sequences.
// Memory returns 0xC0DE0000+addr one cycle after a read and a garbage word otherwise.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall_F, stall_D, flush_D, redirect_en;
  logic [31:0] redirect_pc;
  logic        imem_en;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instr_D, pc_D, pc4_D;
  logic        valid_D, misalign_D;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0100), .NOP(32'h0000_0013)) dut (
    .clk(clk), .reset(reset), .stall_F(stall_F), .stall_D(stall_D),
    .flush_D(flush_D), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr_D(instr_D), .pc_D(pc_D), .pc4_D(pc4_D),
    .valid_D(valid_D), .misalign_D(misalign_D)
  );

  logic [31:0] mem_q     = 32'h0;
  logic        mem_vld_q = 1'b0;

  always @(posedge clk) begin
    mem_vld_q <= imem_en;
    if (imem_en) mem_q <= 32'hC0DE_0000 + imem_addr;
  end

  assign imem_rdata = mem_vld_q ? mem_q : 32'hBADB_AD00;

  typedef struct {
    logic [4:0]  ctl;    // {reset, stall_F, stall_D, flush_D, redirect_en}
    logic [31:0] rpc;
    logic [2:0]  flg;    // expected {valid_D, imem_en, misalign_D}
    logic [31:0] epc;
    logic [31:0] einstr;
    logic [31:0] eaddr;
  } vec_t;

  vec_t tbl [19];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Inputs change 1 time unit after posedge; outputs are checked at the following negedge.
  task automatic run(input string nm, input logic [4:0] ctl, input logic [31:0] rpc,
                     input logic [2:0] flg, input logic [31:0] epc,
                     input logic [31:0] einstr, input logic [31:0] eaddr);
    @(posedge clk);
    #1;
    {reset, stall_F, stall_D, flush_D, redirect_en} = ctl;
    redirect_pc = rpc;
    @(negedge clk);
    cmp({nm, ".valid_D"},    {31'b0, valid_D},    {31'b0, flg[2]});
    cmp({nm, ".imem_en"},    {31'b0, imem_en},    {31'b0, flg[1]});
    cmp({nm, ".misalign_D"}, {31'b0, misalign_D}, {31'b0, flg[0]});
    cmp({nm, ".pc_D"},       pc_D,      epc);
    cmp({nm, ".pc4_D"},      pc4_D,     epc + 32'd4);
    cmp({nm, ".instr_D"},    instr_D,   einstr);
    cmp({nm, ".imem_addr"},  imem_addr, eaddr);
  endtask

  initial begin
    tbl[0]  = '{5'b10000, 32'h0,   3'b000, 32'h0,   32'h13,        32'h100};
    tbl[1]  = '{5'b00000, 32'h0,   3'b010, 32'h0,   32'h13,        32'h100};
    tbl[2]  = '{5'b00000, 32'h0,   3'b110, 32'h100, 32'hC0DE_0100, 32'h104};
    tbl[3]  = '{5'b01100, 32'h0,   3'b100, 32'h104, 32'hC0DE_0104, 32'h108};
    tbl[4]  = '{5'b01100, 32'h0,   3'b100, 32'h104, 32'hC0DE_0104, 32'h108};
    tbl[5]  = '{5'b01100, 32'h0,   3'b100, 32'h104, 32'hC0DE_0104, 32'h108};
    tbl[6]  = '{5'b00000, 32'h0,   3'b110, 32'h104, 32'hC0DE_0104, 32'h108};
    tbl[7]  = '{5'b00001, 32'h200, 3'b100, 32'h108, 32'hC0DE_0108, 32'h10C};
    tbl[8]  = '{5'b00000, 32'h0,   3'b010, 32'h108, 32'h13,        32'h200};
    tbl[9]  = '{5'b00001, 32'h202, 3'b100, 32'h200, 32'hC0DE_0200, 32'h204};
    tbl[10] = '{5'b00000, 32'h0,   3'b010, 32'h200, 32'h13,        32'h200};
    tbl[11] = '{5'b00000, 32'h0,   3'b111, 32'h202, 32'h13,        32'h204};
    tbl[12] = '{5'b00001, 32'h300, 3'b101, 32'h206, 32'h13,        32'h208};
    tbl[13] = '{5'b00000, 32'h0,   3'b010, 32'h206, 32'h13,        32'h300};
    tbl[14] = '{5'b01000, 32'h0,   3'b100, 32'h300, 32'hC0DE_0300, 32'h304};
    tbl[15] = '{5'b00000, 32'h0,   3'b010, 32'h304, 32'h13,        32'h304};
    tbl[16] = '{5'b00100, 32'h0,   3'b100, 32'h304, 32'hC0DE_0304, 32'h308};
    tbl[17] = '{5'b00000, 32'h0,   3'b110, 32'h304, 32'hC0DE_0304, 32'h308};
    tbl[18] = '{5'b00000, 32'h0,   3'b110, 32'h308, 32'hC0DE_0308, 32'h30C};

    reset = 1'b1; stall_F = 1'b0; stall_D = 1'b0; flush_D = 1'b0;
    redirect_en = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 19; i++) begin
      run($sformatf("row%0d", i), tbl[i].ctl, tbl[i].rpc, tbl[i].flg,
          tbl[i].epc, tbl[i].einstr, tbl[i].eaddr);
    end

    // Flush during a stall clears the hold buffer; held pc_F is fetched after release.
    run("flushA1", 5'b01100, 32'h0, 3'b100, 32'h30C, 32'hC0DE_030C, 32'h310);
    run("flushA2", 5'b01110, 32'h0, 3'b100, 32'h30C, 32'hC0DE_030C, 32'h310);
    run("flushA3", 5'b01100, 32'h0, 3'b000, 32'h30C, 32'h13,        32'h310);
    run("flushA4", 5'b00000, 32'h0, 3'b010, 32'h30C, 32'h13,        32'h310);
    run("flushA5", 5'b00000, 32'h0, 3'b110, 32'h310, 32'hC0DE_0310, 32'h314);

    // Redirect together with both stalls: redirect wins.
    run("redirB1", 5'b01101, 32'h400, 3'b100, 32'h314, 32'hC0DE_0314, 32'h318);
    run("redirB2", 5'b00000, 32'h0,   3'b010, 32'h314, 32'h13,        32'h400);
    run("redirB3", 5'b00000, 32'h0,   3'b110, 32'h400, 32'hC0DE_0400, 32'h404);

    // PC and pc4_D wrap at the top of the address space.
    run("wrapC1", 5'b00001, 32'hFFFF_FFFC, 3'b100, 32'h404,       32'hC0DE_0404, 32'h408);
    run("wrapC2", 5'b00000, 32'h0,         3'b010, 32'h404,       32'h13,        32'hFFFF_FFFC);
    run("wrapC3", 5'b00000, 32'h0,         3'b110, 32'hFFFF_FFFC, 32'hC0DD_FFFC, 32'h0);

    // Reset asserted in the middle of a two-cycle stall.
    run("rstD1", 5'b01100, 32'h0, 3'b100, 32'h0,   32'hC0DE_0000, 32'h4);
    run("rstD2", 5'b11100, 32'h0, 3'b100, 32'h0,   32'hC0DE_0000, 32'h4);
    run("rstD3", 5'b01100, 32'h0, 3'b000, 32'h0,   32'h13,        32'h100);
    run("rstD4", 5'b00000, 32'h0, 3'b010, 32'h0,   32'h13,        32'h100);
    run("rstD5", 5'b00000, 32'h0, 3'b110, 32'h100, 32'hC0DE_0100, 32'h104);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
